// File: rtl/serial_subtractor_if.sv
// Handshake and data bundle for the bit-serial subtractor: the requester drives
// start/operands, the subtractor returns status and registered results.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] operand1;
  logic [WIDTH-1:0] operand2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] difference;
  logic             borrow;
  logic             zero;
  logic             overflow;

  modport master (
    output start,
    output operand1,
    output operand2,
    input  busy,
    input  done,
    input  difference,
    input  borrow,
    input  zero,
    input  overflow
  );

  modport slave (
    input  start,
    input  operand1,
    input  operand2,
    output busy,
    output done,
    output difference,
    output borrow,
    output zero,
    output overflow
  );

endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: one full-subtractor cell and a borrow
// flip-flop compute operand1 - operand2 LSB first over WIDTH clock cycles.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_subtractor_if.slave   bus
);

  localparam int CNTW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t           state;
  state_t           stateNext;

  logic [WIDTH-1:0] aSh;
  logic [WIDTH-1:0] bSh;
  logic [WIDTH-1:0] dSh;
  logic             brw;
  logic [CNTW-1:0]  cnt;

  logic [WIDTH-1:0] diffReg;
  logic             borrowReg;
  logic             zeroReg;
  logic             overflowReg;

  logic             bitA;
  logic             bitB;
  logic             bitD;
  logic             bitBout;
  logic [WIDTH-1:0] dShNext;
  logic             lastBit;

  // Full-subtractor cell working on the current LSBs of the operand shifters.
  always_comb begin
    bitA    = aSh[0];
    bitB    = bSh[0];
    bitD    = bitA ^ bitB ^ brw;
    bitBout = (~bitA & bitB) | (~(bitA ^ bitB) & brw);
    dShNext = {bitD, dSh[WIDTH-1:1]};
    lastBit = (cnt == CNTW'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    bus.busy  = 1'b0;
    bus.done  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          stateNext = RUN;
        end
      end
      RUN: begin
        bus.busy = 1'b1;
        if (lastBit) begin
          stateNext = FINISH;
        end
      end
      FINISH: begin
        bus.busy  = 1'b1;
        bus.done  = 1'b1;
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // On the final bit the cell inputs are the latched operand MSBs, which is
  // exactly what the signed overflow test needs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aSh         <= '0;
      bSh         <= '0;
      dSh         <= '0;
      brw         <= 1'b0;
      cnt         <= '0;
      diffReg     <= '0;
      borrowReg   <= 1'b0;
      zeroReg     <= 1'b0;
      overflowReg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            aSh <= bus.operand1;
            bSh <= bus.operand2;
            brw <= 1'b0;
            cnt <= '0;
          end
        end
        RUN: begin
          aSh <= aSh >> 1;
          bSh <= bSh >> 1;
          dSh <= dShNext;
          brw <= bitBout;
          cnt <= cnt + CNTW'(1);
          if (lastBit) begin
            diffReg     <= dShNext;
            borrowReg   <= bitBout;
            zeroReg     <= (dShNext == '0);
            overflowReg <= (bitA != bitB) && (dShNext[WIDTH-1] != bitA);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.difference = diffReg;
  assign bus.borrow     = borrowReg;
  assign bus.zero       = zeroReg;
  assign bus.overflow   = overflowReg;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed corner cases plus random
// operands compared against a plain-arithmetic reference.
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic clk;
  logic rst_n;

  int assertCount;
  int failCount;
  int doneCount;
  int cycleCount;
  logic [WIDTH-1:0] prevDiff;

  serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycleCount++;

  always @(negedge clk) begin
    if (bus.done) doneCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Reference result from integer arithmetic on the operand values.
  task automatic refModel(input logic [WIDTH-1:0] op1, input logic [WIDTH-1:0] op2,
                          output logic [WIDTH-1:0] diff, output logic brw,
                          output logic zro, output logic ovf);
    int ua, ub, sa, sb, sd;
    ua   = int'(op1);
    ub   = int'(op2);
    sa   = (ua >= 128) ? ua - 256 : ua;
    sb   = (ub >= 128) ? ub - 256 : ub;
    sd   = sa - sb;
    diff = WIDTH'((ua - ub + 256) % 256);
    brw  = (ua < ub);
    zro  = (diff == 0);
    ovf  = (sd > 127) || (sd < -128);
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] op1, input logic [WIDTH-1:0] op2);
    logic [WIDTH-1:0] expDiff;
    logic expBrw, expZero, expOvf;
    int cycles;
    refModel(op1, op2, expDiff, expBrw, expZero, expOvf);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.operand1 = op1;
    bus.operand2 = op2;
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.operand1 = WIDTH'($urandom);
    bus.operand2 = WIDTH'($urandom);
    checkOutput("busyAtAccept", 32'(bus.busy), 32'd1);
    cycles = 0;
    do begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      if (cycles == 1) checkOutput("holdDiff", 32'(bus.difference), 32'(prevDiff));
    end while (!bus.done && cycles < 20);
    checkOutput("doneLatency", cycles, 32'd8);
    checkOutput("difference", 32'(bus.difference), 32'(expDiff));
    checkOutput("borrow", 32'(bus.borrow), 32'(expBrw));
    checkOutput("zero", 32'(bus.zero), 32'(expZero));
    checkOutput("overflow", 32'(bus.overflow), 32'(expOvf));
    prevDiff = expDiff;
    @(posedge clk);
    #1;
    checkOutput("donePulseEnd", 32'(bus.done), 32'd0);
    checkOutput("busyLowAfter", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int doneBefore;
    int guard;
    int n;
    int doneCyc[3];

    assertCount  = 0;
    failCount    = 0;
    doneCount    = 0;
    cycleCount   = 0;
    prevDiff     = '0;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.operand1 = '0;
    bus.operand2 = '0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstBusy", 32'(bus.busy), 32'd0);
    checkOutput("rstDone", 32'(bus.done), 32'd0);
    checkOutput("rstDiff", 32'(bus.difference), 32'd0);
    checkOutput("rstBorrow", 32'(bus.borrow), 32'd0);
    checkOutput("rstZero", 32'(bus.zero), 32'd0);
    checkOutput("rstOverflow", 32'(bus.overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(8'h35, 8'h12);
    applyStimulus(8'h12, 8'h35);
    applyStimulus(8'h00, 8'h01);
    applyStimulus(8'h80, 8'h01);
    applyStimulus(8'h7F, 8'hFF);
    applyStimulus(8'h5A, 8'h5A);

    // A second START during RUN must be ignored and operand changes must not leak in.
    @(negedge clk);
    doneBefore   = doneCount;
    bus.start    = 1'b1;
    bus.operand1 = 8'h40;
    bus.operand2 = 8'h10;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus.start    = 1'b1;
    bus.operand1 = 8'h01;
    bus.operand2 = 8'h01;
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.operand1 = 8'hC3;
    bus.operand2 = 8'h3C;
    repeat (20) @(posedge clk);
    #1;
    checkOutput("ignoreStartDones", doneCount - doneBefore, 32'd1);
    checkOutput("ignoreStartDiff", 32'(bus.difference), 32'h30);
    checkOutput("ignoreStartIdle", 32'(bus.busy), 32'd0);
    prevDiff = 8'h30;

    @(negedge clk);
    bus.start    = 1'b1;
    bus.operand1 = 8'h20;
    bus.operand2 = 8'h05;
    n     = 0;
    guard = 0;
    while (n < 3 && guard < 60) begin
      @(posedge clk);
      guard++;
      @(negedge clk);
      if (bus.done) begin
        doneCyc[n] = cycleCount;
        n++;
      end
    end
    bus.start = 1'b0;
    checkOutput("holdHighPulses", n, 32'd3);
    if (n == 3) begin
      checkOutput("holdHighSpacing1", doneCyc[1] - doneCyc[0], 32'd10);
      checkOutput("holdHighSpacing2", doneCyc[2] - doneCyc[1], 32'd10);
    end
    checkOutput("holdHighDiff", 32'(bus.difference), 32'h1B);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("holdHighIdle", 32'(bus.busy), 32'd0);
    prevDiff = 8'h1B;

    // Asynchronous reset in the middle of a run, away from any clock edge.
    @(negedge clk);
    bus.start    = 1'b1;
    bus.operand1 = 8'h77;
    bus.operand2 = 8'h11;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    doneBefore = doneCount;
    rst_n      = 1'b0;
    #1;
    checkOutput("asyncRstBusy", 32'(bus.busy), 32'd0);
    checkOutput("asyncRstDone", 32'(bus.done), 32'd0);
    checkOutput("asyncRstDiff", 32'(bus.difference), 32'd0);
    checkOutput("asyncRstBorrow", 32'(bus.borrow), 32'd0);
    checkOutput("asyncRstZero", 32'(bus.zero), 32'd0);
    checkOutput("asyncRstOverflow", 32'(bus.overflow), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    checkOutput("abandonedNoDone", doneCount - doneBefore, 32'd0);
    checkOutput("abandonedIdle", 32'(bus.busy), 32'd0);
    prevDiff = '0;
    applyStimulus(8'h09, 8'h03);

    // Reset asserted together with START wins.
    @(negedge clk);
    bus.start    = 1'b1;
    bus.operand1 = 8'h44;
    bus.operand2 = 8'h22;
    rst_n        = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rstWithStartBusy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    bus.start = 1'b0;
    rst_n     = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rstWithStartIdle", 32'(bus.busy), 32'd0);
    prevDiff = '0;

    for (int i = 0; i < 40; i++) begin
      applyStimulus(WIDTH'($urandom), WIDTH'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
